// File: rtl/ysyx_23060096_regfile_sb.sv
// ----------------------------------------------------------------------------
// ysyx_23060096_regfile_sb
//
// Integer register file for the pipelined NPC core. It has NRD combinational
// read ports and one write port, plus an integrated scoreboard that keeps one
// busy bit per register.
//
// Register lifecycle:
//   - Issue reserves a destination register by setting its busy bit.
//   - Writeback returns the data and clears the busy bit.
//   - Flush drops every reservation.
//
// Reset and x0:
//   - After reset, a clear sweep zeroes x1..x(NREGS-1) one register per cycle.
//   - x0 reads as zero by address decode; it is never stored or reserved.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   When defined, a read port whose address matches a writeback in the same
//   cycle returns wb_data_i and reports not-busy (write-to-read forwarding).
//   When undefined, reads return the pre-edge array contents.
//
// Parameters:
//   XLEN  data width of each register
//   AW    register address width, NREGS = 2**AW
//   NRD   number of read ports
//
// Ports:
//   clk_i        clock, all state updates on posedge
//   rstn_i       asynchronous active-low reset
//   ready_o      clear sweep finished, traffic accepted
//   rd_addr_i    read addresses, port i at [i*AW +: AW]
//   rd_data_o    read data, port i at [i*XLEN +: XLEN]
//   rd_busy_o    per-port: addressed register has a pending write
//   iss_valid_i  issue request reserving iss_rd_i
//   iss_rd_i     destination register to reserve
//   iss_ok_o     issue accepted this cycle (combinational)
//   wb_valid_i   writeback strobe
//   wb_addr_i    writeback register
//   wb_data_i    writeback data
//   flush_i      drop all reservations
// ----------------------------------------------------------------------------
module ysyx_23060096_regfile_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NRD  = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    output logic                  ready_o,
    input  logic [NRD*AW-1:0]     rd_addr_i,
    output logic [NRD*XLEN-1:0]   rd_data_o,
    output logic [NRD-1:0]        rd_busy_o,
    input  logic                  iss_valid_i,
    input  logic [AW-1:0]         iss_rd_i,
    output logic                  iss_ok_o,
    input  logic                  wb_valid_i,
    input  logic [AW-1:0]         wb_addr_i,
    input  logic [XLEN-1:0]       wb_data_i,
    input  logic                  flush_i
);

    localparam int unsigned NREGS = 2 ** AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   rf_q [NREGS];

    logic run;
    logic wb_en;

    assign run     = (state_q == ST_RUN);
    assign ready_o = run;

    // x0 writes are dropped here, so every consumer of wb_en can assume a
    // non-zero destination.
    assign wb_en = run && wb_valid_i && (wb_addr_i != '0);

    // A busy destination may still be reserved when its writeback lands in
    // the same cycle. In that case the old reservation retires while the new
    // one is taken.
    assign iss_ok_o = run && iss_valid_i && !flush_i &&
                      ((iss_rd_i == '0) || !busy_q[iss_rd_i] ||
                       (wb_valid_i && (wb_addr_i == iss_rd_i)));

    // ------------------------------------------------------------------
    // Control FSM and scoreboard
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == {AW{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Order matters:
                //   1. Writeback clears its bit.
                //   2. Issue sets its bit; a same-register issue wins over
                //      the writeback.
                //   3. Flush wipes everything.
                if (wb_en) begin
                    busy_d[wb_addr_i] = 1'b0;
                end
                if (iss_ok_o && (iss_rd_i != '0)) begin
                    busy_d[iss_rd_i] = 1'b1;
                end
                if (flush_i) begin
                    busy_d = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_CLEAR;
            idx_q   <= {{(AW-1){1'b0}}, 1'b1};
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // The storage is not reset. The sweep provides the zero state instead,
    // so the array stays a plain memory. rf_q[0] is never written.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            rf_q[idx_q] <= '0;
        end else if (wb_en) begin
            rf_q[wb_addr_i] <= wb_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = rd_addr_i[gi*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        // wb_en already excludes x0, so a hit implies a non-zero address.
        assign hit = wb_en && (wb_addr_i == addr);
`else
        assign hit = 1'b0;
`endif

        assign rd_data_o[gi*XLEN +: XLEN] = (!run || (addr == '0)) ? '0 :
                                            hit ? wb_data_i : rf_q[addr];
        assign rd_busy_o[gi] = run && (addr != '0) && !hit && busy_q[addr];
    end

endmodule

// File: tb/tb_ysyx_23060096_regfile_sb.sv
module tb_ysyx_23060096_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        ready;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ok;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ysyx_23060096_regfile_sb dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .ready_o     (ready),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .iss_ok_o    (iss_ok),
        .wb_valid_i  (wb_valid),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .flush_i     (flush)
    );

    typedef struct {
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iv;
        logic [4:0]  ird;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic        e_ok;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic        e_b0;
        logic        e_b1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic iv, input logic [4:0] ird,
                                input logic wv, input logic [4:0] wa,
                                input logic [31:0] wd, input logic fl,
                                input logic e_ok, input logic [31:0] e_d0,
                                input logic [31:0] e_d1, input logic e_b0,
                                input logic e_b1);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1; v.iv = iv; v.ird = ird;
        v.wv = wv; v.wa = wa; v.wd = wd; v.fl = fl;
        v.e_ok = e_ok; v.e_d0 = e_d0; v.e_d1 = e_d1;
        v.e_b0 = e_b0; v.e_b1 = e_b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h want %08h", nm, act, exp);
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rd = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0;
    endtask

    // Called at posedge+1 right after rstn rises. Returns the edge count at
    // which ready first rose, or 0 on timeout. Keeps issue and writeback
    // traffic active during the sweep; the block must ignore it.
    task automatic wait_ready(output int edge_at);
        edge_at = 0;
        iss_valid = 1'b1; iss_rd = 5'd3;
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h1111_1111;
        rd_addr = {5'd2, 5'd1};
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 10) begin
                chk("clear_iss_ok", {31'd0, iss_ok}, 32'd0);
                chk("clear_rd_data", rd_data[31:0], 32'd0);
            end
            if (ready) begin
                edge_at = e;
                idle();
                break;
            end
        end
        idle();
    endtask

    initial begin
        int edge_at;
        int r;

        // Expected values come from a hand-tracked register/busy timeline.
        vecs.push_back(mk(6, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 5, 0, 0, 1, 0, 32'h00001234, 0, 0, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(7, 5, 1, 7, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(5, 3, 0, 0, 1, 7, 32'h55, 0, 0, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(7, 7, 0, 0, 0, 0, 0, 0, 0, 32'h55, 32'h55, 0, 0));
        vecs.push_back(mk(7, 0, 1, 7, 0, 0, 0, 0, 1, 32'h55, 0, 0, 0));
        vecs.push_back(mk(5, 9, 1, 7, 1, 7, 32'hAA, 0, 1, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(7, 7, 1, 7, 0, 0, 0, 0, 0, 32'hAA, 32'hAA, 1, 1));
        vecs.push_back(mk(3, 9, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(3, 9, 1, 9, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(9, 7, 1, 4, 1, 3, 32'h77, 1, 0, 0, 32'hAA, 1, 1));
        vecs.push_back(mk(3, 4, 1, 9, 0, 0, 0, 0, 1, 32'h77, 0, 0, 0));
        vecs.push_back(mk(7, 9, 1, 0, 0, 0, 0, 0, 1, 32'hAA, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(9, 3, 0, 0, 1, 12, 32'h12345678, 0, 0, 0, 32'h77, 1, 0));
        vecs.push_back(mk(12, 12, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 32'h12345678, 0, 0));
        vecs.push_back(mk(5, 6, 0, 0, 1, 6, 32'hCAFE, 0, 0, 32'hDEADBEEF,
                          BYP ? 32'hCAFE : 32'h0, 0, 0));
        vecs.push_back(mk(5, 6, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hCAFE, 0, 0));
        vecs.push_back(mk(6, 6, 1, 6, 0, 0, 0, 0, 1, 32'hCAFE, 32'hCAFE, 0, 0));
        vecs.push_back(mk(9, 6, 0, 0, 1, 6, 32'hBEEF, 0, 0, 0,
                          BYP ? 32'hBEEF : 32'hCAFE, 1, BYP ? 1'b0 : 1'b1));
        vecs.push_back(mk(6, 9, 0, 0, 0, 0, 0, 0, 0, 32'hBEEF, 0, 0, 1));

        // Reset state: outputs quiet even with traffic requested.
        rstn = 1'b0;
        idle();
        iss_valid = 1'b1; iss_rd = 5'd3;
        rd_addr = {5'd2, 5'd1};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_iss_ok", {31'd0, iss_ok}, 32'd0);
        chk("rst_rd_data", rd_data[31:0], 32'd0);
        chk("rst_rd_busy", {30'd0, rd_busy}, 32'd0);

        // Sweep timing: ready must rise exactly at edge 31.
        rstn = 1'b1;
        wait_ready(edge_at);
        chk("ready_edge", edge_at, 32'd31);
        $display("sweep done: ready at edge %0d", edge_at);

        // Every register reads zero after the sweep (x2 proves wb ignored).
        for (r = 0; r < 32; r += 2) begin
            rd_addr = {5'(r + 1), 5'(r)};
            #1;
            chk($sformatf("zero_x%0d", r), rd_data[31:0], 32'd0);
            chk($sformatf("zero_x%0d", r + 1), rd_data[63:32], 32'd0);
        end

        // Directed vector table: inputs applied, pre-edge outputs checked.
        foreach (vecs[i]) begin
            rd_addr   = {vecs[i].ra1, vecs[i].ra0};
            iss_valid = vecs[i].iv;  iss_rd  = vecs[i].ird;
            wb_valid  = vecs[i].wv;  wb_addr = vecs[i].wa;  wb_data = vecs[i].wd;
            flush     = vecs[i].fl;
            #1;
            $display("vec %0d: ra=%0d/%0d iss=%0b ok=%0b d0=%08h d1=%08h busy=%02b",
                     i, vecs[i].ra0, vecs[i].ra1, vecs[i].iv, iss_ok,
                     rd_data[31:0], rd_data[63:32], rd_busy);
            chk($sformatf("v%0d_ok", i), {31'd0, iss_ok}, {31'd0, vecs[i].e_ok});
            chk($sformatf("v%0d_d0", i), rd_data[31:0], vecs[i].e_d0);
            chk($sformatf("v%0d_d1", i), rd_data[63:32], vecs[i].e_d1);
            chk($sformatf("v%0d_b0", i), {31'd0, rd_busy[0]}, {31'd0, vecs[i].e_b0});
            chk($sformatf("v%0d_b1", i), {31'd0, rd_busy[1]}, {31'd0, vecs[i].e_b1});
            @(posedge clk); #1;
        end
        idle();

        // Mid-traffic reset: reserve x10, then pulse rstn between edges.
        iss_valid = 1'b1; iss_rd = 5'd10;
        @(posedge clk); #1;
        idle();
        rd_addr = {5'd10, 5'd5};
        #1;
        chk("pre_rst_busy10", {31'd0, rd_busy[1]}, 32'd1);
        chk("pre_rst_x5", rd_data[31:0], 32'hDEADBEEF);
        #1;
        rstn = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd11;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_busy", {30'd0, rd_busy}, 32'd0);
        chk("midrst_iss_ok", {31'd0, iss_ok}, 32'd0);
        idle();
        @(posedge clk); #1;
        rstn = 1'b1;
        wait_ready(edge_at);
        chk("ready_edge_2", edge_at, 32'd31);
        $display("resweep done: ready at edge %0d", edge_at);
        rd_addr = {5'd10, 5'd5};
        #1;
        chk("post_rst_x5", rd_data[31:0], 32'd0);
        chk("post_rst_busy10", {31'd0, rd_busy[1]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
